qbert_move_ctrl: RTL and testbench
==================================

# qbert_move_ctrl

Player-movement and cube-colour state owner for the pyramid renderer. Accepts a jump request and direction from game logic and tracks Q*bert's row/column on a triangular pyramid. It publishes one-hot current/target cube positions, runs the jump for a fixed number of frames, and updates the per-cube colour state at landing. It is the producer of `position_qb`, `e_next_qb`, `e_color_state`, `done_move` and `e_jump_qb` consumed by every per-cube renderer.

## Interface
- `N_ROWS`, default 7: pyramid rows. Cube count `N_ROWS*(N_ROWS+1)/2` must be ≤ 28.
- `JUMP_FRAMES`, default 16: `frame_tick` pulses per jump (≥1).
- `TOGGLE`, default 0: 0 = landing sets the cube bit; 1 = landing toggles it.
- `clk` in 1: system clock, single domain.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `jump_req` in 1: one-cycle jump request.
- `jump_dir` in 2: 00 up-right (r-1,c), 01 up-left (r-1,c-1), 10 down-left (r+1,c), 11 down-right (r+1,c+1).
- `respawn` in 1: return to the top cube after a fall; colours are kept.
- `new_level` in 1: clear colours and `all_done`, return to the top cube.
- `position_qb` out 28: one-hot current cube.
- `e_next_qb` out 28: one-hot target cube; 0 while falling off the pyramid.
- `e_color_state` out 28: one bit per cube, 1 = target colour.
- `done_move` out 1: one-cycle pulse at a valid landing.
- `e_jump_qb` out 3: {moving, latched dir}.
- `fell` out 1: sticky flag, player left the pyramid.
- `all_done` out 1: sticky flag, all N cubes coloured.

## Operation
- Cube index is r(r+1)/2 + c, with r in 0..N_ROWS-1 and c in 0..r. The one-hot bit for the index is set; bits at and above N are always 0.
- Row and column are held in internal registers; no division is used. The index and target are computed combinationally and every output is registered.
- States:
  - IDLE: accepts `jump_req`. It latches `jump_dir`, computes the target, loads `e_next_qb`, sets `e_jump_qb={1,dir}`, clears the frame counter and goes to MOVE. A target off the pyramid (r<0, r≥N_ROWS, c<0 or c>r) loads `e_next_qb=0` and records an off flag.
  - MOVE: counts `frame_tick`. On the tick that brings the count to JUMP_FRAMES:
    - Valid target: `position_qb<=e_next_qb`, r/c updated, the colour bit is set or toggled, `done_move<=1`, `e_jump_qb[2]<=0`, next state IDLE. If the new colour state has all N bits set, `all_done<=1` and next state CLEAR.
    - Off target: `fell<=1`, `e_jump_qb[2]<=0`, next state FALL. `position_qb`, r/c and colours are unchanged and there is no `done_move`.
  - FALL: ignores `jump_req`. `respawn` clears `fell`, sets `position_qb=e_next_qb=28'h1` with r=c=0, and returns to IDLE.
  - CLEAR: ignores `jump_req` and `respawn`. `new_level` exits it.
- `new_level` in any state: clears `e_color_state`, `all_done` and `fell`, sets both positions to 28'h1, sets `e_jump_qb=0`, cancels any jump, and goes to IDLE.
- Priority: `reset` > `new_level` > `respawn` > `jump_req`. `jump_req` is ignored outside IDLE and is not queued.
- Landing on an already-set cube with TOGGLE=0 still pulses `done_move`; the colour is unchanged.

## Timing
- Reset values: `position_qb=e_next_qb=28'h1`, `e_color_state=0`, `done_move=0`, `e_jump_qb=0`, `fell=0`, `all_done=0`, state IDLE.
- Request to target: `jump_req` at edge k gives `e_next_qb`/`e_jump_qb` valid after edge k. `position_qb` stays unchanged during MOVE, so `position_qb != e_next_qb` throughout the jump.
- Landing: `done_move`, the new `e_color_state` and the new `position_qb` all change on the same edge. Consumers sample `e_color_state` in the cycle where `done_move` is 1.
- Ticks:
  - A `frame_tick` in the same cycle as `jump_req` is not counted.
  - Landing occurs on the JUMP_FRAMES-th tick after the request cycle.
  - Ticks outside MOVE are ignored.
- `done_move` is exactly one cycle wide. The next `jump_req` can be accepted in the cycle `done_move` is high.
- Reset or `new_level` mid-MOVE: the jump is cancelled with no `done_move`, and the reset/new-level values are valid next cycle.

## Test plan
- Reset: assert `reset` 2 cycles -> `position_qb=e_next_qb=28'h1`, colours 0, all flags 0, `e_jump_qb=0`.
- Valid jump (JUMP_FRAMES=4): `jump_req`, dir 10 from the top -> next cycle `e_next_qb=28'h2`, `e_jump_qb=3'b110`. On the 4th tick edge: `position_qb=28'h2`, `e_color_state=28'h2`, `done_move` high 1 cycle.
- Fall: dir 00 from the top -> `e_next_qb=0`. After 4 ticks `fell=1`, `position_qb=28'h1`, colours unchanged, no `done_move`. Then `jump_req` is ignored, and `respawn` gives `fell=0`, positions `28'h1`.
- Toggle (TOGGLE=1): top -> dir 10 -> dir 00 -> dir 10 -> `e_color_state` goes 2 -> 3 -> 1.
- Level clear (N_ROWS=2): dir 10, dir 00, dir 11 -> `e_color_state=3'b111`, `all_done=1`. Further `jump_req` and `respawn` are ignored. `new_level` -> colours 0, `all_done=0`, position `28'h1`.
- Mid-move abort: `reset` after 2 of 4 ticks -> reset values next cycle, no `done_move` ever pulses. Repeat with `new_level` for the same result.

Source files
------------

// File: rtl/qbert_move_ctrl.sv
// qbert_move_ctrl
// Owns Q*bert's position on the triangular pyramid and the per-cube colour
// state. A jump request latches a direction and computes the target cube. The
// jump then runs for JUMP_FRAMES frame ticks. At landing the position moves and
// the cube colour is updated, or the fall flag is raised if the target lies off
// the pyramid.
//
// Parameters
//   N_ROWS      : pyramid rows (cube count N_ROWS*(N_ROWS+1)/2 <= 28)
//   JUMP_FRAMES : frame ticks per jump (>= 1)
//   TOGGLE      : 0 = landing sets the cube bit, 1 = landing toggles it
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   frame_tick     : one-cycle pulse per video frame
//   jump_req       : one-cycle jump request, jump_dir gives direction
//   respawn        : return to the top cube after a fall (colours kept)
//   new_level      : clear colours/flags, return to the top cube
//   position_qb    : one-hot current cube
//   e_next_qb      : one-hot target cube (0 while falling off)
//   e_color_state  : per-cube colour bits
//   done_move      : one-cycle pulse at a valid landing
//   e_jump_qb      : {moving, latched direction}
//   fell, all_done : sticky status flags
module qbert_move_ctrl #(
  parameter int N_ROWS      = 7,
  parameter int JUMP_FRAMES = 16,
  parameter int TOGGLE      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump_req,
  input  logic [1:0]  jump_dir,
  input  logic        respawn,
  input  logic        new_level,
  output logic [27:0] position_qb,
  output logic [27:0] e_next_qb,
  output logic [27:0] e_color_state,
  output logic        done_move,
  output logic [2:0]  e_jump_qb,
  output logic        fell,
  output logic        all_done
);

  localparam int N_CUBES = N_ROWS * (N_ROWS + 1) / 2;
  localparam logic [27:0] FULL_MASK = 28'((64'd1 << N_CUBES) - 64'd1);
  localparam int CW = $clog2(JUMP_FRAMES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(JUMP_FRAMES - 1);
  localparam logic signed [4:0] ROWS_S = 5'(N_ROWS);

  typedef enum logic [1:0] {IDLE, MOVE, FALL, CLEAR} state_t;

  state_t          state, state_n;
  logic [2:0]      row, col, row_n, col_n;
  logic [2:0]      tgt_row, tgt_col, tgt_row_n, tgt_col_n;
  logic            off, off_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [27:0]     pos_n, next_n, color_n, landed_color;
  logic            done_n, fell_n, all_n;
  logic [2:0]      jump_n;

  logic signed [4:0] tgt_r, tgt_c;
  logic [5:0]        r_u, tri_base, tgt_idx;
  logic              tgt_off;
  logic [27:0]       tgt_onehot;

  // Target cube from the current row/col and requested direction. Signed
  // arithmetic lets an up-move off row 0 show up as a negative row.
  always_comb begin
    tgt_r = $signed({2'b00, row});
    tgt_c = $signed({2'b00, col});
    case (jump_dir)
      2'b00: tgt_r = tgt_r - 5'sd1;
      2'b01: begin
        tgt_r = tgt_r - 5'sd1;
        tgt_c = tgt_c - 5'sd1;
      end
      2'b10: tgt_r = tgt_r + 5'sd1;
      default: begin
        tgt_r = tgt_r + 5'sd1;
        tgt_c = tgt_c + 5'sd1;
      end
    endcase
    tgt_off = (tgt_r < 5'sd0) || (tgt_r >= ROWS_S) ||
              (tgt_c < 5'sd0) || (tgt_c > tgt_r);
    // Triangular index r(r+1)/2 + c; only meaningful when on the pyramid.
    r_u        = {3'b000, tgt_r[2:0]};
    tri_base   = (r_u * (r_u + 6'd1)) >> 1;
    tgt_idx    = tri_base + {3'b000, tgt_c[2:0]};
    tgt_onehot = tgt_off ? 28'd0 : ((28'd1 << tgt_idx) & FULL_MASK);
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the next value of each register with hold as default.
  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    tgt_row_n    = tgt_row;
    tgt_col_n    = tgt_col;
    off_n        = off;
    cnt_n        = cnt;
    pos_n        = position_qb;
    next_n       = e_next_qb;
    color_n      = e_color_state;
    done_n       = 1'b0;
    jump_n       = e_jump_qb;
    fell_n       = fell;
    all_n        = all_done;
    landed_color = (TOGGLE != 0) ? (e_color_state ^ e_next_qb)
                                 : (e_color_state | e_next_qb);

    if (new_level) begin
      color_n = 28'd0;
      all_n   = 1'b0;
      fell_n  = 1'b0;
      pos_n   = 28'h1;
      next_n  = 28'h1;
      jump_n  = 3'b000;
      row_n   = 3'd0;
      col_n   = 3'd0;
      off_n   = 1'b0;
      cnt_n   = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (jump_req) begin
            tgt_row_n = tgt_r[2:0];
            tgt_col_n = tgt_c[2:0];
            off_n     = tgt_off;
            next_n    = tgt_onehot;
            jump_n    = {1'b1, jump_dir};
            cnt_n     = '0;
            state_n   = MOVE;
          end
        end
        MOVE: begin
          if (frame_tick) begin
            if (cnt == LAST_CNT) begin
              jump_n[2] = 1'b0;
              if (off) begin
                fell_n  = 1'b1;
                state_n = FALL;
              end else begin
                pos_n   = e_next_qb;
                row_n   = tgt_row;
                col_n   = tgt_col;
                color_n = landed_color;
                done_n  = 1'b1;
                if ((landed_color & FULL_MASK) == FULL_MASK) begin
                  all_n   = 1'b1;
                  state_n = CLEAR;
                end else begin
                  state_n = IDLE;
                end
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        FALL: begin
          if (respawn) begin
            fell_n  = 1'b0;
            pos_n   = 28'h1;
            next_n  = 28'h1;
            row_n   = 3'd0;
            col_n   = 3'd0;
            off_n   = 1'b0;
            state_n = IDLE;
          end
        end
        default: ;  // CLEAR waits for new_level
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      row           <= 3'd0;
      col           <= 3'd0;
      tgt_row       <= 3'd0;
      tgt_col       <= 3'd0;
      off           <= 1'b0;
      cnt           <= '0;
      position_qb   <= 28'h1;
      e_next_qb     <= 28'h1;
      e_color_state <= 28'd0;
      done_move     <= 1'b0;
      e_jump_qb     <= 3'b000;
      fell          <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      state         <= state_n;
      row           <= row_n;
      col           <= col_n;
      tgt_row       <= tgt_row_n;
      tgt_col       <= tgt_col_n;
      off           <= off_n;
      cnt           <= cnt_n;
      position_qb   <= pos_n;
      e_next_qb     <= next_n;
      e_color_state <= color_n;
      done_move     <= done_n;
      e_jump_qb     <= jump_n;
      fell          <= fell_n;
      all_done      <= all_n;
    end
  end

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Testbench for qbert_move_ctrl. Three instances cover the set-mode pyramid,
// the toggle-mode pyramid, and a 2-row pyramid that can be fully coloured.
// Landings are predicted into a scoreboard queue when a jump is issued and
// popped when done_move is seen.
module tb_qbert_move_ctrl;

  localparam int JF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        tick [3];
  logic        jreq [3];
  logic [1:0]  jdir [3];
  logic        resp [3];
  logic        nlev [3];
  logic [27:0] pos  [3];
  logic [27:0] nxt  [3];
  logic [27:0] col  [3];
  logic        dm   [3];
  logic [2:0]  ej   [3];
  logic        fl   [3];
  logic        ad   [3];

  // Reference model state per instance.
  int          m_row [3];
  int          m_col [3];
  logic [27:0] m_color [3];
  int          m_n   [3] = '{7, 7, 2};
  bit          m_tog [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [1:0]  inst;
    logic [27:0] pos;
    logic [27:0] color;
    logic        all_done;
  } rec_t;
  rec_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  qbert_move_ctrl #(.N_ROWS(7), .JUMP_FRAMES(JF), .TOGGLE(0)) dut_set (
    .clk(clk), .reset(rst[0]), .frame_tick(tick[0]), .jump_req(jreq[0]),
    .jump_dir(jdir[0]), .respawn(resp[0]), .new_level(nlev[0]),
    .position_qb(pos[0]), .e_next_qb(nxt[0]), .e_color_state(col[0]),
    .done_move(dm[0]), .e_jump_qb(ej[0]), .fell(fl[0]), .all_done(ad[0]));

  qbert_move_ctrl #(.N_ROWS(7), .JUMP_FRAMES(JF), .TOGGLE(1)) dut_tog (
    .clk(clk), .reset(rst[1]), .frame_tick(tick[1]), .jump_req(jreq[1]),
    .jump_dir(jdir[1]), .respawn(resp[1]), .new_level(nlev[1]),
    .position_qb(pos[1]), .e_next_qb(nxt[1]), .e_color_state(col[1]),
    .done_move(dm[1]), .e_jump_qb(ej[1]), .fell(fl[1]), .all_done(ad[1]));

  qbert_move_ctrl #(.N_ROWS(2), .JUMP_FRAMES(JF), .TOGGLE(0)) dut_small (
    .clk(clk), .reset(rst[2]), .frame_tick(tick[2]), .jump_req(jreq[2]),
    .jump_dir(jdir[2]), .respawn(resp[2]), .new_level(nlev[2]),
    .position_qb(pos[2]), .e_next_qb(nxt[2]), .e_color_state(col[2]),
    .done_move(dm[2]), .e_jump_qb(ej[2]), .fell(fl[2]), .all_done(ad[2]));

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] onehot(input int r, input int c);
    int idx;
    idx = r * (r + 1) / 2 + c;
    return 28'd1 << idx;
  endfunction

  function automatic logic [27:0] fullMask(input int n);
    logic [27:0] m;
    m = '0;
    for (int k = 0; k < n * (n + 1) / 2; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Drives one cycle of inputs on instance i, returns at the following
  // falling edge with the inputs released.
  task automatic applyStimulus(input int i, input logic jr, input logic [1:0] d,
                               input logic tk, input logic rs, input logic rp,
                               input logic nl);
    @(negedge clk);
    jreq[i] = jr; jdir[i] = d; tick[i] = tk;
    rst[i] = rs; resp[i] = rp; nlev[i] = nl;
    @(negedge clk);
    jreq[i] = 1'b0; tick[i] = 1'b0; rst[i] = 1'b0;
    resp[i] = 1'b0; nlev[i] = 1'b0;
  endtask

  task automatic checkResetValues(input int i, input string tag);
    checkOutput({tag, "_pos"}, 64'(pos[i]), 64'h1);
    checkOutput({tag, "_next"}, 64'(nxt[i]), 64'h1);
    checkOutput({tag, "_color"}, 64'(col[i]), 64'h0);
    checkOutput({tag, "_jump"}, 64'(ej[i]), 64'h0);
    checkOutput({tag, "_fell"}, 64'(fl[i]), 64'h0);
    checkOutput({tag, "_alldone"}, 64'(ad[i]), 64'h0);
    checkOutput({tag, "_done"}, 64'(dm[i]), 64'h0);
  endtask

  // Full jump: request (with a tick in the same cycle, which must not count),
  // then JF ticks. Landing expectations go to the scoreboard.
  task automatic doJump(input int i, input logic [1:0] d);
    int tr, tc;
    bit off;
    logic [27:0] exp_next, cur, newc;
    rec_t rec;
    tr = m_row[i] + ((d[1]) ? 1 : -1);
    tc = m_col[i] + ((d == 2'b01) ? -1 : (d == 2'b11) ? 1 : 0);
    off = (tr < 0) || (tr >= m_n[i]) || (tc < 0) || (tc > tr);
    exp_next = off ? 28'd0 : onehot(tr, tc);
    cur = onehot(m_row[i], m_col[i]);
    newc = m_tog[i] ? (m_color[i] ^ exp_next) : (m_color[i] | exp_next);
    if (!off) begin
      rec.inst = 2'(i); rec.pos = exp_next; rec.color = newc;
      rec.all_done = (newc == fullMask(m_n[i]));
      sb_q.push_back(rec);
    end
    applyStimulus(i, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("req_next", 64'(nxt[i]), 64'(exp_next));
    checkOutput("req_jump", 64'(ej[i]), 64'({1'b1, d}));
    for (int k = 0; k < JF; k++) begin
      applyStimulus(i, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k < JF - 1) checkOutput("pos_hold", 64'(pos[i]), 64'(cur));
    end
    checkOutput("land_jump", 64'(ej[i]), 64'({1'b0, d}));
    if (off) begin
      checkOutput("fall_flag", 64'(fl[i]), 64'h1);
      checkOutput("fall_pos", 64'(pos[i]), 64'(cur));
      checkOutput("fall_color", 64'(col[i]), 64'(m_color[i]));
    end else begin
      m_row[i] = tr; m_col[i] = tc; m_color[i] = newc;
      @(negedge clk);
      checkOutput("done_width", 64'(dm[i]), 64'h0);
    end
  endtask

  // Abort a jump after two ticks using reset (use_reset) or new_level.
  task automatic abortJump(input int i, input bit use_reset);
    applyStimulus(i, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(i, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(i, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(i, 1'b0, 2'b00, 1'b0, use_reset, 1'b0, !use_reset);
    m_row[i] = 0; m_col[i] = 0; m_color[i] = '0;
    checkResetValues(i, use_reset ? "abort_rst" : "abort_nl");
    for (int k = 0; k < JF + 1; k++) begin
      applyStimulus(i, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_pos", 64'(pos[i]), 64'h1);
    end
  endtask

  // Scoreboard monitor: each done_move pulse must match the oldest prediction.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dm[i] === 1'b1) begin
        if (sb_q.size() == 0 || sb_q[0].inst != 2'(i)) begin
          checkOutput("spurious_done", 64'(dm[i]), 64'h0);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          checkOutput("sb_pos", 64'(pos[i]), 64'(r.pos));
          checkOutput("sb_color", 64'(col[i]), 64'(r.color));
          checkOutput("sb_alldone", 64'(ad[i]), 64'(r.all_done));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; tick[i] = 1'b0; jreq[i] = 1'b0; jdir[i] = 2'b00;
      resp[i] = 1'b0; nlev[i] = 1'b0;
      m_row[i] = 0; m_col[i] = 0; m_color[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) checkResetValues(i, "reset");

    // Set mode: down-left, back up, then fall off the top.
    doJump(0, 2'b10);
    doJump(0, 2'b00);
    doJump(0, 2'b00);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("fall_ignore_next", 64'(nxt[0]), 64'h0);
    checkOutput("fall_ignore_jump", 64'(ej[0]), 64'h0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    m_row[0] = 0; m_col[0] = 0;
    checkOutput("respawn_fell", 64'(fl[0]), 64'h0);
    checkOutput("respawn_pos", 64'(pos[0]), 64'h1);
    checkOutput("respawn_next", 64'(nxt[0]), 64'h1);
    checkOutput("respawn_color", 64'(col[0]), 64'h3);

    // Toggle mode: colours go 2 -> 3 -> 1.
    doJump(1, 2'b10);
    doJump(1, 2'b00);
    doJump(1, 2'b10);
    checkOutput("toggle_final", 64'(col[1]), 64'h1);

    // Two-row pyramid: colour all three cubes.
    doJump(2, 2'b10);
    doJump(2, 2'b00);
    doJump(2, 2'b11);
    checkOutput("clear_color", 64'(col[2]), 64'h7);
    checkOutput("clear_alldone", 64'(ad[2]), 64'h1);
    applyStimulus(2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_ignore_jump", 64'(ej[2]), 64'h3);
    checkOutput("clear_ignore_pos", 64'(pos[2]), 64'h4);
    applyStimulus(2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_ignore_resp", 64'(pos[2]), 64'h4);
    checkOutput("clear_still_done", 64'(ad[2]), 64'h1);
    applyStimulus(2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    m_row[2] = 0; m_col[2] = 0; m_color[2] = '0;
    checkResetValues(2, "newlevel");

    // Mid-move aborts, then a normal jump to show recovery.
    abortJump(0, 1'b1);
    abortJump(0, 1'b0);
    doJump(0, 2'b11);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
